regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Integer register file for the RV32I core: 32 x 32-bit, x0 hardwired to zero.
- Answers the decode stage's two read requests (address plus read enable) and accepts the write-back stage's write (address, enable, data).
- Has a per-register pending-write scoreboard. It raises `stall` when decode reads a register whose result is still in flight.
- Forwards write-back data to a same-cycle read when that write is the register's last outstanding writer.

Parameters:
- REG_NUM, 32, number of architectural registers; x0 included.
- PEND_W, 2, width of each per-register pending-write counter; maximum 2^PEND_W-1 in-flight writers per register.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high (`Enabled`).
- reg1addr  input  5  read port 1 address, from decode.
- reg1re  input  1  read port 1 enable.
- reg1data  output  32  read port 1 data.
- reg2addr  input  5  read port 2 address.
- reg2re  input  1  read port 2 enable.
- reg2data  output  32  read port 2 data.
- issue_valid  input  1  decode issues an instruction this cycle.
- issue_rd  input  5  destination of the issuing instruction.
- issue_we  input  1  issuing instruction writes `issue_rd`.
- issue_ready  output  1  low when `pend[issue_rd]` is saturated.
- wb_we  input  1  write-back enable.
- wb_addr  input  5  write-back address.
- wb_data  input  32  write-back data.
- stall  output  1  an enabled read hits a pending register that is not forwardable this cycle.
- wb_err  output  1  sticky flag: write-back arrived for a register with pending count 0.

Behaviour:
- Reset (rst high at an edge): all registers become 0, all pend counters become 0, `wb_err` becomes 0.
- While rst is high, the combinational outputs are forced: `reg1data` = `reg2data` = 0, `stall` = 0, `issue_ready` = 0.
- Reset mid-operation discards all in-flight scoreboard state. No write-back is performed in the reset cycle.
- Reads are combinational, zero latency. For port n:
  - If `regNre` is 0 or `regNaddr` is 0, data = 0.
  - Else if `wb_we` and `wb_addr` == `regNaddr` and `wb_addr` != 0, data = `wb_data` (bypass).
  - Else data = the register contents.
- Stall per port, with a = `regNaddr`: `stall_n` = `regNre` & (a != 0) & (pend[a] != 0) & !(`wb_we` & `wb_addr` == a & pend[a] == 1).
- `stall` = `stall_1` | `stall_2`.
- Reads always use the pend value from before this cycle's issue, so an instruction that reads and writes the same rd does not stall on itself.
- Register write: at the edge, if `wb_we` and `wb_addr` != 0, then regs[`wb_addr`] <= `wb_data`. Writes to x0 are dropped.
- Define inc = `issue_valid` & `issue_we` & (`issue_rd` != 0) & `issue_ready`, and dec = `wb_we` & (`wb_addr` != 0).
- Pending counter update rules:
  - inc and dec on the same register: count unchanged.
  - inc only: count + 1.
  - dec only with count > 0: count - 1.
  - dec with count == 0: count stays 0 and `wb_err` <= 1.
- `issue_ready` = !(`issue_we` & `issue_rd` != 0 & pend[`issue_rd`] == 2^PEND_W-1).
  - Decode must hold issue while `issue_ready` or `stall` is low.
  - This block ignores the inc when `issue_ready` = 0. It does not gate on `stall`; that is decode's job.
- x0 never has a pending count, never stalls, and always reads 0.
- Write-back does not depend on `stall`. Write-back in a stall cycle still updates the register and its counter.

Optional Feature:
- Macro: `REGFILE_DBGPORT_EN`.
- Defined: adds ports `dbg_addr` input 5 and `dbg_data` output 32.
  - `dbg_data` is the registered value of regs[`dbg_addr`] (1-cycle latency, no bypass).
  - `dbg_data` is 0 after reset and 0 for address 0.
  - Also adds `dbg_pend_any` output 1: the OR of all pend counters being nonzero.
- Undefined: these ports and their logic are absent. Core behaviour is identical.

Test Plan:
- Reset, then read x1/x2 with `reg1re` = `reg2re` = 1 -> data 0, `stall` = 0, `wb_err` = 0.
- Issue rd = 5, we = 1. Next cycle read x5 -> `stall` = 1. Then write-back x5 = 0x0000_00AB in a cycle where x5 is read -> `stall` = 0, `reg1data` = 0x0000_00AB same cycle. Following cycle reads 0x0000_00AB with pend 0.
- Issue rd = 7 three times (PEND_W = 2) -> `issue_ready` = 0 on the 4th attempt. Count stays 3; `stall` on read of x7 persists through the first two write-backs and clears only on the third.
- Write-back x0 = 0xFFFF_FFFF, then read x0 -> 0, no `stall`, no `wb_err`.
- Write-back x9 with pend[x9] = 0 -> x9 written, `wb_err` = 1 and stays 1 until rst.
- Issue rd = 3 and write-back rd = 3 in the same cycle with pend = 1 -> pend stays 1. Reset asserted mid-flight -> all pend 0, and a read of x3 returns 0 with no `stall`.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb -- RV32I integer register file with a per-register
// pending-write scoreboard.
//
// Two combinational read ports serve decode. One write port serves
// write-back. A small saturating counter per register tracks how many
// issued writers are still in flight. `stall` is raised when decode reads
// a register that still has outstanding writers. The exception is when
// this cycle's write-back is the last outstanding writer: that value is
// forwarded to the read instead.
//
// Optional feature, enabled by defining REGFILE_DBGPORT_EN:
//   dbg_addr / dbg_data  registered debug read (1-cycle latency, no bypass)
//   dbg_pend_any         high while any register has an in-flight writer
// With the macro undefined those ports and their logic are absent.

module regfile_sb #(
  parameter int REG_NUM = 32,
  parameter int PEND_W  = 2
) (
  input  logic        clk,
  input  logic        rst,
  // decode read ports
  input  logic [4:0]  reg1addr,
  input  logic        reg1re,
  output logic [31:0] reg1data,
  input  logic [4:0]  reg2addr,
  input  logic        reg2re,
  output logic [31:0] reg2data,
  // decode issue (scoreboard increment)
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        issue_we,
  output logic        issue_ready,
  // write-back (register write and scoreboard decrement)
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  // status
  output logic        stall,
  output logic        wb_err
`ifdef REGFILE_DBGPORT_EN
  ,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data,
  output logic        dbg_pend_any
`endif
);

  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [31:0]       regs [REG_NUM];
  logic [PEND_W-1:0] pend [REG_NUM];

  // Two read ports folded into arrays so they share a single description.
  logic [4:0]  rd_addr  [2];
  logic        rd_re    [2];
  logic [31:0] rd_data  [2];
  logic        rd_stall [2];

  logic               inc;
  logic               dec;
  logic [REG_NUM-1:0] inc_vec;
  logic [REG_NUM-1:0] dec_vec;
  logic               wb_err_set;

  assign rd_addr[0] = reg1addr;
  assign rd_addr[1] = reg2addr;
  assign rd_re[0]   = reg1re;
  assign rd_re[1]   = reg2re;

  // Issue is accepted unless it targets a register whose counter is saturated.
  always_comb begin
    // NOTE: every signal driven in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    issue_ready = 1'b1;
    if (rst) begin
      issue_ready = 1'b0;
    end else if (issue_we && (issue_rd != 5'd0) && (pend[issue_rd] == PEND_MAX)) begin
      issue_ready = 1'b0;
    end
  end

  // Scoreboard increment/decrement, decoded one-hot per register.
  always_comb begin
    inc     = issue_valid & issue_we & (issue_rd != 5'd0) & issue_ready;
    dec     = wb_we & (wb_addr != 5'd0);
    inc_vec = '0;
    dec_vec = '0;
    if (inc) inc_vec[issue_rd] = 1'b1;
    if (dec) dec_vec[wb_addr]  = 1'b1;
    // A write-back with no recorded writer is an error. A simultaneous issue
    // to the same register cancels the decrement, so that case is not flagged.
    wb_err_set = dec & ~inc_vec[wb_addr] & (pend[wb_addr] == '0);
  end

  // Read ports: zero-latency data with write-back bypass, and per-port stall.
  // Both use the pend value from before this cycle's issue, so an
  // instruction never stalls on its own destination.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p]  = '0;
      rd_stall[p] = 1'b0;
      if (!rst && rd_re[p] && (rd_addr[p] != 5'd0)) begin
        if (wb_we && (wb_addr == rd_addr[p])) begin
          rd_data[p] = wb_data;
        end else begin
          rd_data[p] = regs[rd_addr[p]];
        end
        rd_stall[p] = (pend[rd_addr[p]] != '0) &&
                      !(wb_we && (wb_addr == rd_addr[p]) && (pend[rd_addr[p]] == PEND_ONE));
      end
    end
  end

  assign reg1data = rd_data[0];
  assign reg2data = rd_data[1];
  assign stall    = rd_stall[0] | rd_stall[1];

  // Architectural state: register contents, pending counters, sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the register array is cleared on reset on purpose. x1..x31 must read 0 after reset, so this must not be left to power-up state.
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
      wb_err <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values, independent of statement order.
      if (dec) regs[wb_addr] <= wb_data;
      for (int i = 1; i < REG_NUM; i++) begin
        case ({inc_vec[i], dec_vec[i]})
          2'b10:   pend[i] <= pend[i] + PEND_ONE;
          2'b01:   if (pend[i] != '0) pend[i] <= pend[i] - PEND_ONE;
          default: pend[i] <= pend[i];
        endcase
      end
      if (wb_err_set) wb_err <= 1'b1;
    end
  end

`ifdef REGFILE_DBGPORT_EN
  // Registered debug read of the architectural contents, with no bypass.
  always_ff @(posedge clk) begin
    if (rst) begin
      dbg_data <= '0;
    end else if (dbg_addr == 5'd0) begin
      dbg_data <= '0;
    end else begin
      dbg_data <= regs[dbg_addr];
    end
  end

  // High while any register still has an in-flight writer.
  always_comb begin
    dbg_pend_any = 1'b0;
    for (int i = 0; i < REG_NUM; i++) begin
      if (pend[i] != '0) dbg_pend_any = 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb -- directed self-checking bench for regfile_sb.
// Inputs change 1 time unit after a rising edge. Outputs are checked
// combinationally before the next rising edge.

module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  reg1addr, reg2addr, issue_rd, wb_addr;
  logic        reg1re, reg2re, issue_valid, issue_we, wb_we;
  logic [31:0] reg1data, reg2data, wb_data;
  logic        issue_ready, stall, wb_err;

  int tests = 0;
  int fails = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst),
    .reg1addr(reg1addr), .reg1re(reg1re), .reg1data(reg1data),
    .reg2addr(reg2addr), .reg2re(reg2re), .reg2data(reg2data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_ready(issue_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .stall(stall), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg1addr = 5'd0; reg1re = 1'b0; reg2addr = 5'd0; reg2re = 1'b0;
    issue_valid = 1'b0; issue_rd = 5'd0; issue_we = 1'b0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'h0;
  endtask

  task automatic issue(input logic [4:0] rd);
    issue_valid = 1'b1; issue_we = 1'b1; issue_rd = rd;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
  endtask

  task automatic test_reset();
    idle(); rst = 1'b1;
    reg1re = 1'b1; reg1addr = 5'd1; issue(5'd1); wb(5'd4, 32'h44);
    tick(); tick();
    tests++; if (reg1data !== 32'h0) begin fails++; $display("FAIL rst_forced_r1 got=%h exp=%h", reg1data, 32'h0); end
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL rst_forced_ready got=%b exp=0", issue_ready); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL rst_forced_stall got=%b exp=0", stall); end
    idle(); rst = 1'b0;
    reg1re = 1'b1; reg1addr = 5'd1; reg2re = 1'b1; reg2addr = 5'd2; #1;
    tests++; if (reg1data !== 32'h0) begin fails++; $display("FAIL reset_x1 got=%h exp=%h", reg1data, 32'h0); end
    tests++; if (reg2data !== 32'h0) begin fails++; $display("FAIL reset_x2 got=%h exp=%h", reg2data, 32'h0); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got=%b exp=0", stall); end
    tests++; if (wb_err !== 1'b0) begin fails++; $display("FAIL reset_wb_err got=%b exp=0", wb_err); end
    reg1addr = 5'd4; #1;
    tests++; if (reg1data !== 32'h0) begin fails++; $display("FAIL reset_no_wb got=%h exp=%h", reg1data, 32'h0); end
  endtask

  task automatic test_stall_forward();
    idle(); issue(5'd5); #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL sf_ready got=%b exp=1", issue_ready); end
    tick();
    idle(); reg1re = 1'b1; reg1addr = 5'd5; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL sf_stall got=%b exp=1", stall); end
    wb(5'd5, 32'h0000_00AB); #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sf_fwd_stall got=%b exp=0", stall); end
    tests++; if (reg1data !== 32'h0000_00AB) begin fails++; $display("FAIL sf_fwd_data got=%h exp=%h", reg1data, 32'hAB); end
    tick();
    idle(); reg1re = 1'b1; reg1addr = 5'd5; #1;
    tests++; if (reg1data !== 32'h0000_00AB) begin fails++; $display("FAIL sf_after_data got=%h exp=%h", reg1data, 32'hAB); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sf_after_stall got=%b exp=0", stall); end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 3; k++) begin
      idle(); issue(5'd7); #1;
      tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL sat_ready%0d got=%b exp=1", k, issue_ready); end
      tick();
    end
    idle(); issue(5'd7); #1;
    tests++; if (issue_ready !== 1'b0) begin fails++; $display("FAIL sat_ready_full got=%b exp=0", issue_ready); end
    tick();
    for (int k = 0; k < 3; k++) begin
      idle(); reg1re = 1'b1; reg1addr = 5'd7; wb(5'd7, 32'h70 + k); #1;
      tests++; if (stall !== (k != 2)) begin fails++; $display("FAIL sat_wb%0d_stall got=%b exp=%b", k, stall, k != 2); end
      tick();
    end
    idle(); reg1re = 1'b1; reg1addr = 5'd7; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL sat_drained_stall got=%b exp=0", stall); end
    tests++; if (reg1data !== 32'h72) begin fails++; $display("FAIL sat_data got=%h exp=%h", reg1data, 32'h72); end
    tests++; if (wb_err !== 1'b0) begin fails++; $display("FAIL sat_wb_err got=%b exp=0", wb_err); end
  endtask

  task automatic test_x0();
    idle(); wb(5'd0, 32'hFFFF_FFFF);
    reg1re = 1'b1; reg1addr = 5'd0; reg2re = 1'b1; reg2addr = 5'd0; #1;
    tests++; if (reg1data !== 32'h0) begin fails++; $display("FAIL x0_bypass got=%h exp=%h", reg1data, 32'h0); end
    tick();
    idle(); reg1re = 1'b1; reg1addr = 5'd0; reg2re = 1'b1; reg2addr = 5'd0; issue(5'd0); #1;
    tests++; if (reg2data !== 32'h0) begin fails++; $display("FAIL x0_read got=%h exp=%h", reg2data, 32'h0); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL x0_stall got=%b exp=0", stall); end
    tests++; if (wb_err !== 1'b0) begin fails++; $display("FAIL x0_wb_err got=%b exp=0", wb_err); end
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL x0_ready got=%b exp=1", issue_ready); end
    tick();
  endtask

  task automatic test_dual_port();
    idle(); issue(5'd10); tick();
    idle(); issue(5'd11); tick();
    idle(); reg1re = 1'b1; reg1addr = 5'd10; reg2re = 1'b1; reg2addr = 5'd11; wb(5'd10, 32'hA); #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL dp_port2_stall got=%b exp=1", stall); end
    tests++; if (reg1data !== 32'hA) begin fails++; $display("FAIL dp_r1_fwd got=%h exp=%h", reg1data, 32'hA); end
    tick();
    wb(5'd11, 32'hB); #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL dp_clear_stall got=%b exp=0", stall); end
    tests++; if (reg1data !== 32'hA) begin fails++; $display("FAIL dp_r1 got=%h exp=%h", reg1data, 32'hA); end
    tests++; if (reg2data !== 32'hB) begin fails++; $display("FAIL dp_r2_fwd got=%h exp=%h", reg2data, 32'hB); end
    tick();
    idle(); reg1addr = 5'd10; reg2re = 1'b1; reg2addr = 5'd11; #1;
    tests++; if (reg1data !== 32'h0) begin fails++; $display("FAIL dp_re_off got=%h exp=%h", reg1data, 32'h0); end
    tests++; if (reg2data !== 32'hB) begin fails++; $display("FAIL dp_r2 got=%h exp=%h", reg2data, 32'hB); end
  endtask

  task automatic test_wb_err();
    idle(); wb(5'd9, 32'h1234_5678); #1;
    tests++; if (wb_err !== 1'b0) begin fails++; $display("FAIL err_before got=%b exp=0", wb_err); end
    tick();
    idle(); reg1re = 1'b1; reg1addr = 5'd9; #1;
    tests++; if (wb_err !== 1'b1) begin fails++; $display("FAIL err_set got=%b exp=1", wb_err); end
    tests++; if (reg1data !== 32'h1234_5678) begin fails++; $display("FAIL err_written got=%h exp=%h", reg1data, 32'h12345678); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL err_stall got=%b exp=0", stall); end
    tick(); tick(); tick();
    tests++; if (wb_err !== 1'b1) begin fails++; $display("FAIL err_sticky got=%b exp=1", wb_err); end
  endtask

  task automatic test_same_cycle_and_reset();
    idle(); issue(5'd3); tick();
    idle(); issue(5'd3); wb(5'd3, 32'h33); tick();
    idle(); reg1re = 1'b1; reg1addr = 5'd3; #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL same_pend_kept got=%b exp=1", stall); end
    tests++; if (reg1data !== 32'h33) begin fails++; $display("FAIL same_data got=%h exp=%h", reg1data, 32'h33); end
    rst = 1'b1; tick();
    tests++; if (reg1data !== 32'h0) begin fails++; $display("FAIL mid_rst_data got=%h exp=%h", reg1data, 32'h0); end
    rst = 1'b0; #1;
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mid_rst_stall got=%b exp=0", stall); end
    tests++; if (reg1data !== 32'h0) begin fails++; $display("FAIL mid_rst_x3 got=%h exp=%h", reg1data, 32'h0); end
    tests++; if (wb_err !== 1'b0) begin fails++; $display("FAIL mid_rst_err got=%b exp=0", wb_err); end
    reg1addr = 5'd7; issue(5'd7); #1;
    tests++; if (issue_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_x7_ready got=%b exp=1", issue_ready); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mid_rst_x7_stall got=%b exp=0", stall); end
    tick();
  endtask

  initial begin
    idle(); rst = 1'b1;
    test_reset();
    test_stall_forward();
    test_saturation();
    test_x0();
    test_dual_port();
    test_wb_err();
    test_same_cycle_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
